election_house_ctrl: RTL and testbench
======================================

ELECTION_HOUSE_CTRL -- requirements
Module: election_house_ctrl

Interface
REQ-001 Parameter CAPTURE_FRAMES, default 60, frames a player SHALL hold the house to score a vote.
REQ-002 Parameter COOLDOWN_FRAMES, default 180, frames the house SHALL stay locked after a vote.
REQ-003 Parameter MAX_SCORE, default 15, saturation and win value of each score.
REQ-004 clk  in  1  system clock, single clock domain, all logic SHALL be rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 startOfFrame  in  1  one-cycle pulse per VGA frame.
REQ-007 enable  in  1  game running; low SHALL pause the block.
REQ-008 p1Inside, p2Inside  in  1 each  tank overlaps house area.
REQ-009 p1Req, p2Req  in  1 each  level vote request from player key.
REQ-010 coolingDown  out  1  high during COOLDOWN, drives house drawer colour swap.
REQ-011 capturing  out  1  high during CAPTURING.
REQ-012 owner  out  2  00 none, 01 player 1, 10 player 2; 11 never driven.
REQ-013 progress  out  9  frames accumulated in current capture or cooldown.
REQ-014 vote1, vote2  out  1 each  one-cycle vote award pulse.
REQ-015 score1, score2  out  4 each  saturating vote counts.
REQ-016 winner  out  2  owner encoding of first player reaching MAX_SCORE, sticky.

Function
REQ-017 States SHALL be IDLE, CAPTURING, AWARD, COOLDOWN, LOCKED; all outputs SHALL be registered.
REQ-018 IDLE: player i eligible when piReq && piInside && enable; one eligible -> CAPTURING, owner=i, progress=0 next cycle.
REQ-019 Both eligible same cycle: grant the player not favoured last; round-robin pointer SHALL reset to favour player 1 and SHALL toggle only on AWARD.
REQ-020 CAPTURING: owner's Inside or Req low -> IDLE, owner=00, progress=0, no cooldown, no vote.
REQ-021 CAPTURING: progress SHALL increment on startOfFrame only while the other player's Inside is low (contested house halts count).
REQ-022 CAPTURING: startOfFrame with progress==CAPTURE_FRAMES-1 and uncontested -> AWARD.
REQ-023 AWARD: exactly one cycle; vote pulse for owner; owner score +1 saturating at MAX_SCORE; pointer toggles; next COOLDOWN with progress=0.
REQ-024 If the incremented score equals MAX_SCORE and winner==00, winner SHALL take owner value that same cycle; next state LOCKED instead of COOLDOWN.
REQ-025 COOLDOWN: coolingDown=1; progress increments on startOfFrame; at progress==COOLDOWN_FRAMES-1 with startOfFrame -> IDLE, owner=00, progress=0.
REQ-026 COOLDOWN: requests SHALL be ignored; a held request SHALL be granted in the first IDLE cycle.
REQ-027 LOCKED: terminal until reset; coolingDown=1, owner holds winner, no votes.
REQ-028 enable low: CAPTURING aborts per REQ-020; COOLDOWN counter freezes; IDLE grants blocked; AWARD completes.
REQ-029 startOfFrame in the AWARD cycle SHALL not count toward cooldown.
REQ-030 progress width SHALL cover max(CAPTURE_FRAMES, COOLDOWN_FRAMES)-1; elaboration SHALL fail if either parameter exceeds 511 or is 0.

Reset
REQ-031 reset SHALL force IDLE, owner=00, progress=0, coolingDown=0, capturing=0, vote1=vote2=0, scores=0, winner=00, pointer favours player 1, in the next cycle, including mid-capture or mid-cooldown.

Structure
REQ-032 Package election_pkg SHALL hold the state enum, owner encoding constants (OWNER_NONE, OWNER_P1, OWNER_P2) and parameter defaults.
REQ-033 Sub-module election_frame_timer SHALL implement the clear/enable/startOfFrame progress counter with terminal-count flag, instantiated once.
REQ-034 owner encoding SHALL match player colour mapping used by the house drawer.

Verification
REQ-035 CAPTURE_FRAMES=4: p1Req,p1Inside held, 4 frame pulses -> vote1 one cycle after 4th pulse, score1=1, coolingDown=1 next cycle.
REQ-036 Both players eligible same cycle after reset -> owner=01; after award and cooldown, both eligible again -> owner=10.
REQ-037 p1 capturing, progress=2, p2Inside high for 3 frames -> progress stays 2, resumes counting when p2Inside falls.
REQ-038 p1Inside drops at progress=3 -> IDLE, owner=00, progress=0, no vote, coolingDown=0.
REQ-039 MAX_SCORE=2: p2 wins two captures -> winner=10 on second AWARD, state LOCKED, further requests ignored, reset clears all.
REQ-040 reset asserted mid-COOLDOWN (progress=5) -> all outputs at REQ-031 values one cycle later.

Source files
------------

// File: rtl/election_pkg.sv
// Shared definitions for the election house controller: FSM states,
// owner encoding (matches the house drawer's player colours) and defaults.
package election_pkg;

  localparam int unsigned CAPTURE_FRAMES_DEF  = 60;
  localparam int unsigned COOLDOWN_FRAMES_DEF = 180;
  localparam int unsigned MAX_SCORE_DEF       = 15;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_P1   = 2'b01;
  localparam logic [1:0] OWNER_P2   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURING,
    ST_AWARD,
    ST_COOLDOWN,
    ST_LOCKED
  } state_e;

  // Bits needed to hold max(a, b) - 1, never less than one.
  function automatic int unsigned progress_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/election_frame_timer.sv
// Frame-based progress counter shared by the capture and cooldown phases;
// flags when the count sits on the caller-selected terminal value.
module election_frame_timer #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             count,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] progress,
  output logic             at_term
);

  logic [WIDTH-1:0] progress_q;
  logic [WIDTH-1:0] progress_d;

  always_comb begin
    progress_d = progress_q;
    if (clear) begin
      progress_d = '0;
    end else if (count) begin
      progress_d = progress_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      progress_q <= '0;
    end else begin
      progress_q <= progress_d;
    end
  end

  assign progress = progress_q;
  assign at_term  = (progress_q == term);

endmodule

// File: rtl/election_house_ctrl.sv
// Level-vote house: a player holds the house for a number of frames to
// score a vote, after which the house cools down; first to the max wins.
module election_house_ctrl
  import election_pkg::*;
#(
  parameter int unsigned CAPTURE_FRAMES  = CAPTURE_FRAMES_DEF,
  parameter int unsigned COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
  parameter int unsigned MAX_SCORE       = MAX_SCORE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       enable,
  input  logic       p1Inside,
  input  logic       p2Inside,
  input  logic       p1Req,
  input  logic       p2Req,
  output logic       coolingDown,
  output logic       capturing,
  output logic [1:0] owner,
  output logic [8:0] progress,
  output logic       vote1,
  output logic       vote2,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner
);

  if (CAPTURE_FRAMES == 0 || CAPTURE_FRAMES > 511) begin : g_bad_capture
    $error("CAPTURE_FRAMES must be within 1..511");
  end
  if (COOLDOWN_FRAMES == 0 || COOLDOWN_FRAMES > 511) begin : g_bad_cooldown
    $error("COOLDOWN_FRAMES must be within 1..511");
  end
  if (MAX_SCORE == 0 || MAX_SCORE > 15) begin : g_bad_score
    $error("MAX_SCORE must be within 1..15");
  end

  localparam int unsigned PW = progress_width(CAPTURE_FRAMES, COOLDOWN_FRAMES);
  localparam logic [PW-1:0] CAP_TERM  = PW'(CAPTURE_FRAMES - 1);
  localparam logic [PW-1:0] COOL_TERM = PW'(COOLDOWN_FRAMES - 1);
  localparam logic [3:0]    MAX_S     = 4'(MAX_SCORE);

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] winner_q, winner_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic       ptr_q, ptr_d;
  logic       vote1_q, vote1_d;
  logic       vote2_q, vote2_d;
  logic       capturing_q, capturing_d;
  logic       cooling_q, cooling_d;

  logic          tmr_clear, tmr_count, tmr_at_term;
  logic [PW-1:0] tmr_term, tmr_progress;

  logic elig1, elig2, own_hold, other_in;

  election_frame_timer #(
    .WIDTH (PW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmr_clear),
    .count    (tmr_count),
    .term     (tmr_term),
    .progress (tmr_progress),
    .at_term  (tmr_at_term)
  );

  always_comb begin
    elig1    = p1Req && p1Inside && enable;
    elig2    = p2Req && p2Inside && enable;
    own_hold = (owner_q == OWNER_P1) ? (p1Inside && p1Req) : (p2Inside && p2Req);
    other_in = (owner_q == OWNER_P1) ? p2Inside : p1Inside;

    state_d   = state_q;
    owner_d   = owner_q;
    winner_d  = winner_q;
    score1_d  = score1_q;
    score2_d  = score2_q;
    ptr_d     = ptr_q;
    vote1_d   = 1'b0;
    vote2_d   = 1'b0;
    tmr_clear = 1'b0;
    tmr_count = 1'b0;
    tmr_term  = CAP_TERM;

    case (state_q)
      ST_IDLE: begin
        tmr_clear = 1'b1;
        // ptr_q low favours player 1 when both are eligible together.
        if (elig1 && !(elig2 && ptr_q)) begin
          state_d = ST_CAPTURING;
          owner_d = OWNER_P1;
        end else if (elig2) begin
          state_d = ST_CAPTURING;
          owner_d = OWNER_P2;
        end
      end
      ST_CAPTURING: begin
        if (!(own_hold && enable)) begin
          state_d   = ST_IDLE;
          owner_d   = OWNER_NONE;
          tmr_clear = 1'b1;
        end else if (startOfFrame && !other_in) begin
          if (tmr_at_term) begin
            // Vote, score and winner are registered on entry to AWARD so
            // they are all visible during the single AWARD cycle.
            state_d   = ST_AWARD;
            tmr_clear = 1'b1;
            ptr_d     = ~ptr_q;
            if (owner_q == OWNER_P1) begin
              vote1_d  = 1'b1;
              score1_d = (score1_q == MAX_S) ? score1_q : score1_q + 4'd1;
              if (score1_d == MAX_S && winner_q == OWNER_NONE) winner_d = OWNER_P1;
            end else begin
              vote2_d  = 1'b1;
              score2_d = (score2_q == MAX_S) ? score2_q : score2_q + 4'd1;
              if (score2_d == MAX_S && winner_q == OWNER_NONE) winner_d = OWNER_P2;
            end
          end else begin
            tmr_count = 1'b1;
          end
        end
      end
      ST_AWARD: begin
        tmr_clear = 1'b1;
        state_d   = (winner_q != OWNER_NONE) ? ST_LOCKED : ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        tmr_term = COOL_TERM;
        if (enable && startOfFrame) begin
          if (tmr_at_term) begin
            state_d   = ST_IDLE;
            owner_d   = OWNER_NONE;
            tmr_clear = 1'b1;
          end else begin
            tmr_count = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        tmr_clear = 1'b1;
        owner_d   = winner_q;
      end
      default: begin
        state_d   = ST_IDLE;
        owner_d   = OWNER_NONE;
        tmr_clear = 1'b1;
      end
    endcase

    capturing_d = (state_d == ST_CAPTURING);
    cooling_d   = (state_d == ST_COOLDOWN) || (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_NONE;
      winner_q    <= OWNER_NONE;
      score1_q    <= '0;
      score2_q    <= '0;
      ptr_q       <= 1'b0;
      vote1_q     <= 1'b0;
      vote2_q     <= 1'b0;
      capturing_q <= 1'b0;
      cooling_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      winner_q    <= winner_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      ptr_q       <= ptr_d;
      vote1_q     <= vote1_d;
      vote2_q     <= vote2_d;
      capturing_q <= capturing_d;
      cooling_q   <= cooling_d;
    end
  end

  always_comb begin
    progress           = '0;
    progress[PW-1:0]   = tmr_progress;
  end

  assign coolingDown = cooling_q;
  assign capturing   = capturing_q;
  assign owner       = owner_q;
  assign vote1       = vote1_q;
  assign vote2       = vote2_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_election_house_ctrl.sv
// Bench for election_house_ctrl: event-level model of the capture, vote and
// cooldown behaviour, per-cycle output comparison, directed scenarios and
// random stimulus.
module tb_election_house_ctrl;

  localparam int CAP  = 4;
  localparam int COOL = 7;
  localparam int MAXS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0, startOfFrame = 1'b0, enable = 1'b0;
  logic       p1Inside = 1'b0, p2Inside = 1'b0, p1Req = 1'b0, p2Req = 1'b0;
  logic       coolingDown, capturing, vote1, vote2;
  logic [1:0] owner, winner;
  logic [8:0] progress;
  logic [3:0] score1, score2;

  election_house_ctrl #(
    .CAPTURE_FRAMES  (CAP),
    .COOLDOWN_FRAMES (COOL),
    .MAX_SCORE       (MAXS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .enable       (enable),
    .p1Inside     (p1Inside),
    .p2Inside     (p2Inside),
    .p1Req        (p1Req),
    .p2Req        (p2Req),
    .coolingDown  (coolingDown),
    .capturing    (capturing),
    .owner        (owner),
    .progress     (progress),
    .vote1        (vote1),
    .vote2        (vote2),
    .score1       (score1),
    .score2       (score2),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  // Model: phase 0 free, 1 being captured, 2 vote moment, 3 cooling, 4 game over.
  int m_phase = 0, m_owner = 0, m_frames = 0, m_fav = 1, m_win = 0;
  int m_score[1:2] = '{0, 0};
  int m_vote[1:2]  = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit want1, want2, holds, contested;
    m_vote[1] = 0;
    m_vote[2] = 0;
    if (reset) begin
      m_phase = 0; m_owner = 0; m_frames = 0; m_fav = 1; m_win = 0;
      m_score[1] = 0; m_score[2] = 0;
      return;
    end
    case (m_phase)
      0: begin
        want1 = p1Req && p1Inside && enable;
        want2 = p2Req && p2Inside && enable;
        if (want1 && want2) m_owner = m_fav;
        else if (want1)     m_owner = 1;
        else if (want2)     m_owner = 2;
        if (want1 || want2) begin m_phase = 1; m_frames = 0; end
      end
      1: begin
        holds     = (m_owner == 1) ? (p1Inside && p1Req) : (p2Inside && p2Req);
        contested = (m_owner == 1) ? p2Inside : p1Inside;
        if (!holds || !enable) begin
          m_phase = 0; m_owner = 0; m_frames = 0;
        end else if (startOfFrame && !contested) begin
          m_frames++;
          if (m_frames == CAP) begin
            m_phase = 2; m_frames = 0;
            m_fav = 3 - m_fav;
            m_vote[m_owner] = 1;
            if (m_score[m_owner] < MAXS) m_score[m_owner]++;
            if (m_score[m_owner] == MAXS && m_win == 0) m_win = m_owner;
          end
        end
      end
      2: m_phase = (m_win != 0) ? 4 : 3;
      3: begin
        if (enable && startOfFrame) begin
          m_frames++;
          if (m_frames == COOL) begin m_phase = 0; m_owner = 0; m_frames = 0; end
        end
      end
      default: ;
    endcase
  endtask

  always @(posedge clk) model_step();

  wire [24:0] dut_vec = {coolingDown, capturing, owner, progress, vote1, vote2,
                         score1, score2, winner};

  function automatic logic [24:0] model_vec();
    return {1'(m_phase == 3 || m_phase == 4), 1'(m_phase == 1), 2'(m_owner),
            9'(m_frames), 1'(m_vote[1]), 1'(m_vote[2]), 4'(m_score[1]),
            4'(m_score[2]), 2'(m_win)};
  endfunction

  always @(negedge clk) begin
    if (armed) check("cycle_outputs", 32'(dut_vec), 32'(model_vec()));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sof_pulses(input int n);
    repeat (n) begin
      startOfFrame = 1'b1; tick(1);
      startOfFrame = 1'b0; tick(1);
    end
  endtask

  task automatic do_reset();
    p1Inside = 1'b0; p2Inside = 1'b0; p1Req = 1'b0; p2Req = 1'b0;
    startOfFrame = 1'b0; enable = 1'b1;
    reset = 1'b1; tick(1);
    reset = 1'b0;
  endtask

  initial begin
    enable = 1'b1;
    do_reset();
    armed = 1'b1;
    check("reset_all_zero", 32'(dut_vec), 32'h0);

    // Single capture: vote after the 4th frame pulse, then cooldown.
    p1Req = 1'b1; p1Inside = 1'b1; tick(1);
    check("cap_start_owner", 32'(owner), 32'h1);
    check("cap_start_capturing", 32'(capturing), 32'h1);
    sof_pulses(3);
    check("cap_progress_3", 32'(progress), 32'd3);
    startOfFrame = 1'b1; tick(1);
    check("award_vote1", 32'(vote1), 32'h1);
    check("award_score1", 32'(score1), 32'h1);
    startOfFrame = 1'b0; tick(1);
    check("award_then_cooling", 32'(coolingDown), 32'h1);
    check("vote1_one_cycle", 32'(vote1), 32'h0);

    // Round robin: tie goes to p1, next tie goes to p2.
    do_reset();
    p1Req = 1'b1; p1Inside = 1'b1; p2Req = 1'b1; p2Inside = 1'b1; tick(1);
    check("tie_first_p1", 32'(owner), 32'h1);
    p2Inside = 1'b0;
    sof_pulses(4);
    p2Inside = 1'b1;
    sof_pulses(COOL);
    check("tie_second_p2", 32'(owner), 32'h2);

    // Contested house halts counting, then an abort.
    do_reset();
    p1Req = 1'b1; p1Inside = 1'b1; tick(1);
    sof_pulses(2);
    check("contest_before", 32'(progress), 32'd2);
    p2Inside = 1'b1;
    sof_pulses(3);
    check("contest_halted", 32'(progress), 32'd2);
    p2Inside = 1'b0;
    sof_pulses(1);
    check("contest_resumed", 32'(progress), 32'd3);
    p1Inside = 1'b0; tick(1);
    check("abort_outputs", 32'(dut_vec), 32'h0);

    // p2 wins the game with two captures; LOCKED ignores further requests.
    do_reset();
    p2Req = 1'b1; p2Inside = 1'b1; tick(1);
    sof_pulses(4);
    check("win_first_score2", 32'(score2), 32'h1);
    check("win_first_no_winner", 32'(winner), 32'h0);
    sof_pulses(COOL);
    check("win_recapture", 32'(capturing), 32'h1);
    sof_pulses(3);
    startOfFrame = 1'b1; tick(1);
    check("win_winner", 32'(winner), 32'h2);
    check("win_score2", 32'(score2), 32'h2);
    check("win_vote2", 32'(vote2), 32'h1);
    startOfFrame = 1'b0; tick(1);
    check("locked_cooling", 32'(coolingDown), 32'h1);
    check("locked_owner", 32'(owner), 32'h2);
    p2Req = 1'b0; p2Inside = 1'b0; p1Req = 1'b1; p1Inside = 1'b1;
    sof_pulses(8);
    check("locked_no_capture", 32'(capturing), 32'h0);
    check("locked_score1", 32'(score1), 32'h0);
    do_reset();
    check("locked_reset_clear", 32'(dut_vec), 32'h0);

    // Reset in the middle of cooldown.
    p1Req = 1'b1; p1Inside = 1'b1; tick(1);
    sof_pulses(4);
    p1Req = 1'b0;
    sof_pulses(5);
    check("midcool_progress", 32'(progress), 32'd5);
    check("midcool_cooling", 32'(coolingDown), 32'h1);
    reset = 1'b1; tick(1); reset = 1'b0;
    check("midcool_reset", 32'(dut_vec), 32'h0);

    // Random sticky stimulus, occasionally reset.
    for (int ep = 0; ep < 20; ep++) begin
      do_reset();
      p1Inside = 1'($urandom_range(0, 1)); p1Req = 1'($urandom_range(0, 1));
      p2Inside = 1'($urandom_range(0, 1)); p2Req = 1'($urandom_range(0, 1));
      for (int c = 0; c < 300; c++) begin
        startOfFrame = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 9) == 0)  p1Inside = ~p1Inside;
        if ($urandom_range(0, 9) == 0)  p1Req    = ~p1Req;
        if ($urandom_range(0, 7) == 0)  p2Inside = ~p2Inside;
        if ($urandom_range(0, 9) == 0)  p2Req    = ~p2Req;
        if ($urandom_range(0, 19) == 0) enable   = ~enable;
        reset = ($urandom_range(0, 249) == 0);
        tick(1);
      end
      reset = 1'b0;
    end

    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
